// File: rtl/gmii_rx_checker.sv
// gmii_rx_checker: GMII receive frame checker.
// Finds preamble/SFD, streams DA..FCS bytes out, checks CRC-32 residue and
// frame length, and keeps saturating good/bad frame counters.
module gmii_rx_checker #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxEn,
  input  logic        RxErr,
  input  logic [7:0]  RxData,
  input  logic        Clear,
  output logic        PayloadValid,
  output logic [7:0]  PayloadData,
  output logic        PayloadSof,
  output logic        PayloadEof,
  output logic        FrameGood,
  output logic        FrameBad,
  output logic [15:0] FrameLength,
  output logic [2:0]  ErrFlags,
  output logic [23:0] RxCNT,
  output logic [23:0] ErrCNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0] CRC_MAGIC = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L     = MIN_LEN[15:0];
  localparam logic [15:0] MAX_L     = MAX_LEN[15:0];

  // Stage-1 input registers
  logic        en_q, er_q;
  logic [7:0]  dat_q;

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        rxerr_q, rxerr_d;
  logic        lenerr_q, lenerr_d;
  logic        from_data_q, from_data_d;
  // One-byte hold stage: lets EOF be flagged once RxEn fall is seen
  logic        hold_v_q, hold_v_d;
  logic [7:0]  byte_q, byte_d;
  logic        sof_q, sof_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic [15:0] flen_q, flen_d;
  logic [2:0]  flags_q, flags_d;
  logic [23:0] rxcnt_q, rxcnt_d;
  logic [23:0] errcnt_q, errcnt_d;
  logic [2:0]  end_flags;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i[2:0]]) r = (r >> 1) ^ CRC_POLY;
      else                  r = r >> 1;
    end
    return r;
  endfunction

  // Frame FSM, CRC/length accumulation and end-of-frame status
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    rxerr_d     = rxerr_q;
    lenerr_d    = lenerr_q;
    from_data_d = from_data_q;
    hold_v_d    = 1'b0;
    byte_d      = byte_q;
    sof_d       = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    flen_d      = flen_q;
    flags_d     = flags_q;
    end_flags   = {lenerr_q | (len_q < MIN_L) | (len_q > MAX_L), rxerr_q, crc_q != CRC_MAGIC};

    case (state_q)
      S_IDLE: begin
        from_data_d = 1'b0;
        if (en_q) state_d = (dat_q == 8'h55) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (dat_q == 8'hD5) begin
          state_d  = S_DATA;
          crc_d    = '1;
          len_d    = '0;
          rxerr_d  = 1'b0;
          lenerr_d = 1'b0;
        end else if (dat_q != 8'h55) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!en_q) begin
          state_d = S_IDLE;
          good_d  = (end_flags == 3'b000);
          bad_d   = (end_flags != 3'b000);
          flen_d  = len_q;
          flags_d = end_flags;
        end else if (len_q >= MAX_L) begin
          // Overlength: byte is counted but neither emitted nor CRC'd
          state_d     = S_DROP;
          from_data_d = 1'b1;
          lenerr_d    = 1'b1;
          len_d       = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        end else begin
          len_d    = len_q + 16'd1;
          crc_d    = crc_byte(crc_q, dat_q);
          rxerr_d  = rxerr_q | er_q;
          hold_v_d = 1'b1;
          byte_d   = dat_q;
          sof_d    = (len_q == 16'd0);
        end
      end
      default: begin
        if (!en_q) begin
          state_d     = S_IDLE;
          from_data_d = 1'b0;
          if (from_data_q) begin
            bad_d   = 1'b1;
            flen_d  = len_q;
            flags_d = end_flags;
          end
        end
      end
    endcase
  end

  // Saturating counters; Clear overrides a same-cycle increment
  always_comb begin
    rxcnt_d  = rxcnt_q;
    errcnt_d = errcnt_q;
    if (Clear) begin
      rxcnt_d  = '0;
      errcnt_d = '0;
    end else begin
      if (good_q && rxcnt_q != '1)  rxcnt_d  = rxcnt_q + 24'd1;
      if (bad_q  && errcnt_q != '1) errcnt_d = errcnt_q + 24'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      er_q        <= 1'b0;
      dat_q       <= '0;
      state_q     <= S_IDLE;
      crc_q       <= '1;
      len_q       <= '0;
      rxerr_q     <= 1'b0;
      lenerr_q    <= 1'b0;
      from_data_q <= 1'b0;
      hold_v_q    <= 1'b0;
      byte_q      <= '0;
      sof_q       <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      flen_q      <= '0;
      flags_q     <= '0;
      rxcnt_q     <= '0;
      errcnt_q    <= '0;
    end else begin
      en_q        <= RxEn;
      er_q        <= RxErr;
      dat_q       <= RxData;
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      rxerr_q     <= rxerr_d;
      lenerr_q    <= lenerr_d;
      from_data_q <= from_data_d;
      hold_v_q    <= hold_v_d;
      byte_q      <= byte_d;
      sof_q       <= sof_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      flen_q      <= flen_d;
      flags_q     <= flags_d;
      rxcnt_q     <= rxcnt_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign PayloadValid = hold_v_q;
  assign PayloadData  = byte_q;
  assign PayloadSof   = sof_q;
  // Held byte is last if RxEn just fell or the length limit was reached
  assign PayloadEof   = hold_v_q & (~en_q | (len_q >= MAX_L));
  assign FrameGood    = good_q;
  assign FrameBad     = bad_q;
  assign FrameLength  = flen_q;
  assign ErrFlags     = flags_q;
  assign RxCNT        = rxcnt_q;
  assign ErrCNT       = errcnt_q;

endmodule

// File: tb/tb_gmii_rx_checker.sv
// Bench for gmii_rx_checker: directed and random frames checked against a
// frame-level reference model (FCS match, length bounds, RxErr, counters).
module tb_gmii_rx_checker;

  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic        clk = 1'b0;
  logic        rst_n, RxEn, RxErr, Clear;
  logic [7:0]  RxData;
  logic        PayloadValid, PayloadSof, PayloadEof, FrameGood, FrameBad;
  logic [7:0]  PayloadData;
  logic [15:0] FrameLength;
  logic [2:0]  ErrFlags;
  logic [23:0] RxCNT, ErrCNT;

  gmii_rx_checker #(.MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .RxEn(RxEn), .RxErr(RxErr), .RxData(RxData),
    .Clear(Clear), .PayloadValid(PayloadValid), .PayloadData(PayloadData),
    .PayloadSof(PayloadSof), .PayloadEof(PayloadEof), .FrameGood(FrameGood),
    .FrameBad(FrameBad), .FrameLength(FrameLength), .ErrFlags(ErrFlags),
    .RxCNT(RxCNT), .ErrCNT(ErrCNT)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit sof; bit eof; byte unsigned d; int cyc; } obyte_t;
  typedef struct { bit good; bit bad; logic [15:0] len; logic [2:0] fl; int cyc; } stat_t;
  obyte_t oq[$];
  stat_t  sq[$];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (PayloadValid) oq.push_back('{PayloadSof, PayloadEof, PayloadData, cyc});
    if (FrameGood || FrameBad) sq.push_back('{FrameGood, FrameBad, FrameLength, ErrFlags, cyc});
  end

  int checks = 0, failures = 0;
  int drv_cyc, last_cyc;
  byte unsigned fr[$];
  bit fer[$];
  logic [23:0] exp_rx = '0, exp_err = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit en, input bit er, input logic [7:0] d,
                       input bit clr = 1'b0, input bit rn = 1'b1);
    @(posedge clk);
    #1;
    RxEn = en; RxErr = er; RxData = d; Clear = clr; rst_n = rn;
    drv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Ethernet CRC-32 over the first cnt bytes of fr
  function automatic logic [31:0] crc_of(input int cnt);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c ^= {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic make_frame(input int plen, input bit incr);
    logic [31:0] f;
    fr.delete(); fer.delete();
    for (int i = 0; i < plen; i++) fr.push_back(incr ? i[7:0] : 8'($urandom));
    f = ~crc_of(plen);
    for (int k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
    for (int i = 0; i < fr.size(); i++) fer.push_back(1'b0);
  endtask

  task automatic send(input int npre);
    repeat (npre) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fr.size(); i++) drive(1'b1, fer[i], fr[i]);
    last_cyc = drv_cyc;
  endtask

  function automatic logic [23:0] sat(input logic [23:0] v);
    return (v == 24'hFFFFFF) ? v : v + 24'd1;
  endfunction

  // Compare one completed frame against the reference model
  task automatic check_frame(input string tag);
    int n, ne, badb;
    bit rx, fcs_ok, lerr, anyerr;
    logic [31:0] c;
    n  = fr.size();
    ne = (n > MAXL) ? MAXL : n;
    chk({tag, ".nbytes"}, oq.size(), ne);
    badb = 0;
    for (int i = 0; i < ne; i++)
      if (i >= oq.size()) badb++;
      else if (oq[i].d != fr[i] || oq[i].sof != (i == 0) || oq[i].eof != (i == ne - 1)) badb++;
    chk({tag, ".bytes"}, badb, 0);
    rx = 1'b0;
    for (int i = 0; i < ne; i++) rx |= fer[i];
    fcs_ok = 1'b0;
    if (ne >= 4) begin
      c = ~crc_of(ne - 4);
      fcs_ok = ({fr[ne-1], fr[ne-2], fr[ne-3], fr[ne-4]} == c);
    end
    lerr   = (n < MINL) || (n > MAXL);
    anyerr = lerr | rx | ~fcs_ok;
    chk({tag, ".nstat"}, sq.size(), 1);
    if (sq.size() > 0) begin
      chk({tag, ".good"}, sq[0].good, !anyerr);
      chk({tag, ".bad"}, sq[0].bad, anyerr);
      chk({tag, ".flags"}, sq[0].fl, {lerr, rx, ~fcs_ok});
      if (n <= MAXL) begin
        chk({tag, ".len"}, sq[0].len, n);
        chk({tag, ".stat_lat"}, sq[0].cyc - last_cyc, 3);
        if (oq.size() >= ne) chk({tag, ".eof_lat"}, oq[ne-1].cyc - last_cyc, 2);
      end
    end
    if (anyerr) exp_err = sat(exp_err);
    else        exp_rx  = sat(exp_rx);
    chk({tag, ".rxcnt"}, RxCNT, exp_rx);
    chk({tag, ".errcnt"}, ErrCNT, exp_err);
  endtask

  initial begin
    int plen, kind, idx, r;
    rst_n = 1'b0; RxEn = 1'b0; RxErr = 1'b0; RxData = '0; Clear = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    chk("rst.valid", PayloadValid, 0);
    chk("rst.good", FrameGood, 0);
    chk("rst.bad", FrameBad, 0);
    chk("rst.len", FrameLength, 0);
    chk("rst.flags", ErrFlags, 0);
    chk("rst.rxcnt", RxCNT, 0);
    chk("rst.errcnt", ErrCNT, 0);
    idle(2);

    // Good 64-byte frame, incrementing payload
    oq.delete(); sq.delete();
    make_frame(60, 1'b1);
    send(7); idle(5);
    check_frame("good64");

    // Same frame, one payload bit flipped
    oq.delete(); sq.delete();
    make_frame(60, 1'b1); fr[10] ^= 8'h04;
    send(7); idle(5);
    check_frame("crcbad");

    // RxErr on byte 10
    oq.delete(); sq.delete();
    make_frame(60, 1'b0); fer[10] = 1'b1;
    send(7); idle(5);
    check_frame("rxerr");

    // Runt with good FCS
    oq.delete(); sq.delete();
    make_frame(36, 1'b0);
    send(7); idle(5);
    check_frame("runt40");

    // Overlength frame, cut at MAX_LEN
    oq.delete(); sq.delete();
    make_frame(1596, 1'b0);
    send(7); idle(5);
    check_frame("long1600");
    chk("long1600.no_extra", oq.size(), MAXL);

    // Broken preamble: nothing out, no status
    oq.delete(); sq.delete();
    drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h12);
    repeat (20) drive(1'b1, 1'b0, 8'($urandom));
    idle(5);
    chk("badpre.nbytes", oq.size(), 0);
    chk("badpre.nstat", sq.size(), 0);

    // Random frames
    for (int t = 0; t < 8; t++) begin
      oq.delete(); sq.delete();
      kind = $urandom_range(0, 3);
      plen = (kind == 3) ? $urandom_range(10, 59) : $urandom_range(60, 140);
      make_frame(plen, 1'b0);
      idx = $urandom_range(0, fr.size() - 1);
      if (kind == 1) fr[idx] ^= 8'(1 << $urandom_range(0, 7));
      if (kind == 2) fer[idx] = 1'b1;
      send($urandom_range(1, 7)); idle(5);
      check_frame($sformatf("rand%0d", t));
    end

    // Back-to-back good frames, 1-cycle IFG
    oq.delete(); sq.delete();
    make_frame(60, 1'b1);
    send(7); idle(1); send(7); idle(5);
    exp_rx = sat(sat(exp_rx));
    chk("b2b.nstat", sq.size(), 2);
    r = 0;
    foreach (sq[i]) if (sq[i].good && !sq[i].bad && sq[i].len == 16'd64) r++;
    chk("b2b.goods", r, 2);
    chk("b2b.nbytes", oq.size(), 128);
    chk("b2b.rxcnt", RxCNT, exp_rx);

    // Clear coincident with second FrameGood
    oq.delete(); sq.delete();
    send(7); idle(1); send(7);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr.good_now", FrameGood, 1);
    drive(1'b0, 1'b0, 8'h00);
    exp_rx = '0; exp_err = '0;
    chk("clr.rxcnt", RxCNT, 0);
    chk("clr.errcnt", ErrCNT, 0);
    idle(3);
    chk("clr.rxcnt_hold", RxCNT, 0);

    // Reset pulse in the middle of a frame
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
    drive(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h45);
    chk("midrst.valid", PayloadValid, 0);
    chk("midrst.len", FrameLength, 0);
    chk("midrst.flags", ErrFlags, 0);
    oq.delete(); sq.delete();
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 8'(8'h46 + i));
    idle(5);
    chk("midrst.nbytes", oq.size(), 0);
    chk("midrst.nstat", sq.size(), 0);
    exp_rx = '0; exp_err = '0;
    oq.delete(); sq.delete();
    make_frame(60, 1'b1);
    send(7); idle(5);
    check_frame("afterrst");

    // Saturation of the good-frame counter
    @(negedge clk);
    force dut.rxcnt_q = 24'hFFFFFF;
    @(negedge clk);
    release dut.rxcnt_q;
    exp_rx = 24'hFFFFFF;
    oq.delete(); sq.delete();
    make_frame(60, 1'b1);
    send(7); idle(5);
    check_frame("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
